cnn_run_ctrl: RTL and testbench
===============================

Name: cnn_run_ctrl

Overview:
Run controller for the 4x4 cellular-neural-network array (fourbyfour).
- Holds the A/B templates, the U inputs, the bias I and the iteration limit in a write-only config register file.
- On start, initialises the array and enables state updates, then watches the 16 Y outputs for convergence or for the iteration limit.
- Latches the final Y image and reports done, converged and the iteration count.
- Replaces the hard-wired constants at the top level, so one array can run successive templates and images.

Parameters:
WIDTH, 9, fixed-point word {sign, 2^3..2^0, 2^-1..2^-4}; 1.0 = 9'h010
ITER_W, 16, width of the iteration limit and iteration counter
STABLE_CYCLES, 4, consecutive unchanged Y compares that count as convergence (>=1)
ARR_LAT, 1, RUN cycles after entry during which Y compares are masked (array latency)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe
cfg_addr  in  6  0-8 A1..A9, 9-17 B1..B9, 18-33 U1..U16, 34 I, 35 max_iter (low ITER_W bits of wdata, zero-extended)
cfg_wdata  in  16  write data; template, U and I use [WIDTH-1:0]
cfg_err  out  1  1-cycle pulse: write rejected
start  in  1  run request, level-sampled
abort  in  1  cancel the current run
y_in  in  16*WIDTH  array outputs Y1..Y16; Y1 in the LSBs
a_tmpl  out  9*WIDTH  A1..A9 to the array
b_tmpl  out  9*WIDTH  B1..B9 to the array
u_out  out  16*WIDTH  U1..U16 to the array
i_bias  out  WIDTH  I to the array
arr_init  out  1  1-cycle pulse: array loads its initial state
arr_en  out  1  array state-update enable
busy  out  1  high in INIT and RUN
done  out  1  1-cycle completion pulse
converged  out  1  valid with done; held until the next start
iter_cnt  out  ITER_W  number of arr_en cycles in the last or current run
y_result  out  16*WIDTH  Y image latched at done

Behaviour:
- Reset (async, rst_n=0):
  - All template, U and I registers = 0; max_iter = 256.
  - State = IDLE; every output = 0.
- Config writes:
  - A write is accepted only in IDLE and takes effect at the next edge.
  - A write in INIT or RUN, or any write with cfg_addr 36-63, is ignored and pulses cfg_err the next cycle.
  - Template, U and I outputs are driven straight from their registers.
- FSM states: IDLE, INIT, RUN, DONE.
- IDLE:
  - start=1 -> INIT. converged, stable_cnt and iter_cnt clear.
  - A write in the same cycle as start is applied, so INIT already sees the new value.
- INIT (1 cycle):
  - arr_init=1, busy=1.
  - max_iter=0 -> DONE with converged=0, iter_cnt=0.
  - Otherwise -> RUN.
- RUN:
  - arr_en=1 and busy=1 every cycle; iter_cnt increments per cycle; y_prev <= y_in every cycle.
  - Compares start at RUN cycle index k >= ARR_LAT (k=0 is the first RUN cycle).
  - y_in == y_prev increments stable_cnt; any difference clears it to 0.
  - Converged exit: compare equal and stable_cnt == STABLE_CYCLES-1 -> DONE with converged=1.
  - Limit exit: the iter_cnt increment reaches max_iter -> DONE with converged=0.
  - If both exits fire in the same cycle, converged=1 wins.
  - Counter wrap is impossible because the limit check fires first.
- DONE (1 cycle):
  - done=1, arr_en=0, busy=0; y_result <= y_in.
  - -> IDLE. A start seen in DONE is ignored.
- start while busy: ignored.
- abort in INIT or RUN:
  - -> IDLE next edge, with arr_en=0.
  - No done pulse; y_result and converged unchanged; iter_cnt keeps its partial count.
- Reset mid-run: immediate IDLE and all reset values; the config is lost.
- Equality compare: exact bitwise over all 16*WIDTH bits; no tolerance.

Decomposition:
- Package cnn_pkg holds:
  - WIDTH and the fixed-point constants ONE=9'h010, NEG_ONE=9'h1F0.
  - Address constants ADDR_A0=0, ADDR_B0=9, ADDR_U0=18, ADDR_I=34, ADDR_MAXIT=35.
  - The state enum.
- Sub-module cnn_cfg_regfile holds the config registers, address decode and cfg_err.
- The FSM, counters and compare stay in cnn_run_ctrl.

Test Plan:
- Reset check: assert rst_n=0 mid-clock -> all outputs 0 asynchronously. Then start with no writes and y_in toggling every cycle -> done after 256 arr_en cycles, converged=0, iter_cnt=256.
- Edge-detect load: write A5=9'h010, B5=9'h040, other B=9'h1F0, U6/U7/U10/U11=9'h010, I=9'h1B0 -> a_tmpl, b_tmpl, u_out and i_bias match bit-for-bit one cycle later.
- Convergence: start with y_in constant 16 x 9'h010 -> arr_init 1 cycle, RUN cycles k=0..4, done on the next cycle with converged=1, iter_cnt=5, y_result=all 9'h010.
- Limit: max_iter=10, y_in alternating each cycle -> done with converged=0, iter_cnt=10. A second run with max_iter=0 -> INIT then DONE, iter_cnt=0, arr_en never high.
- Abort and illegal writes: abort at RUN k=3 -> busy low next cycle, no done, y_result unchanged. A cfg write during RUN and a write to addr 40 in IDLE -> each pulses cfg_err, registers unchanged.
- Simultaneous exit: max_iter=5, y_in constant -> converged and limit exits coincide at k=4 -> converged=1, iter_cnt=5.

Source files
------------

// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
//   Shared definitions for the 4x4 CNN run controller:
//   - fixed-point word width and the +1.0 / -1.0 constants
//   - config register address map
//   - run FSM state encoding
// ---------------------------------------------------------------------------
package cnn_pkg;

  // Fixed-point word {sign, 2^3..2^0, 2^-1..2^-4}; 1.0 = 9'h010
  localparam int WIDTH = 9;
  localparam logic [WIDTH-1:0] ONE     = 9'h010;
  localparam logic [WIDTH-1:0] NEG_ONE = 9'h1F0;

  // Array geometry: 3x3 template taps, 4x4 cells
  localparam int N_TAP  = 9;
  localparam int N_CELL = 16;

  // Config bus geometry
  localparam int CFG_AW = 6;
  localparam int CFG_DW = 16;

  // Config address map
  localparam logic [CFG_AW-1:0] ADDR_A0    = 6'd0;
  localparam logic [CFG_AW-1:0] ADDR_B0    = 6'd9;
  localparam logic [CFG_AW-1:0] ADDR_U0    = 6'd18;
  localparam logic [CFG_AW-1:0] ADDR_I     = 6'd34;
  localparam logic [CFG_AW-1:0] ADDR_MAXIT = 6'd35;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_t;

endpackage

// File: rtl/cnn_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// cnn_run_ctrl_if
//   Config write bus of the CNN run controller.
//   cfg_we    : write strobe
//   cfg_addr  : register address (see cnn_pkg address map)
//   cfg_wdata : write data
//   cfg_err   : 1-cycle pulse, previous write rejected
//   master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface cnn_run_ctrl_if;

  logic                        cfg_we;
  logic [cnn_pkg::CFG_AW-1:0]  cfg_addr;
  logic [cnn_pkg::CFG_DW-1:0]  cfg_wdata;
  logic                        cfg_err;

  modport master (
    output cfg_we,
    output cfg_addr,
    output cfg_wdata,
    input  cfg_err
  );

  modport slave (
    input  cfg_we,
    input  cfg_addr,
    input  cfg_wdata,
    output cfg_err
  );

endinterface

// File: rtl/cnn_cfg_regfile.sv
// ---------------------------------------------------------------------------
// cnn_cfg_regfile
//   Write-only configuration registers for the CNN array.
//   clk, rst_n : clock, asynchronous active-low reset
//   idle       : controller is in IDLE; writes are accepted only then
//   cfg        : config write bus (slave side), cfg_err pulses on reject
//   a_tmpl     : A1..A9 (A1 in LSBs)
//   b_tmpl     : B1..B9
//   u_out      : U1..U16
//   i_bias     : bias I
//   max_iter   : iteration limit (reset value 256)
// ---------------------------------------------------------------------------
module cnn_cfg_regfile
  import cnn_pkg::*;
#(
  parameter int ITER_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      idle,
  cnn_run_ctrl_if.slave             cfg,
  output logic [N_TAP*WIDTH-1:0]    a_tmpl,
  output logic [N_TAP*WIDTH-1:0]    b_tmpl,
  output logic [N_CELL*WIDTH-1:0]   u_out,
  output logic [WIDTH-1:0]          i_bias,
  output logic [ITER_W-1:0]         max_iter
);

  logic [WIDTH-1:0] a_reg [N_TAP];
  logic [WIDTH-1:0] b_reg [N_TAP];
  logic [WIDTH-1:0] u_reg [N_CELL];

  logic addr_ok;
  logic wr_ok;
  logic err_q;

  assign addr_ok = (cfg.cfg_addr <= ADDR_MAXIT);
  assign wr_ok   = cfg.cfg_we && idle && addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAP; i++) begin
        a_reg[i] <= '0;
        b_reg[i] <= '0;
      end
      for (int i = 0; i < N_CELL; i++) begin
        u_reg[i] <= '0;
      end
      i_bias   <= '0;
      max_iter <= ITER_W'(256);
      err_q    <= 1'b0;
    end else begin
      // Rejected: out-of-map address, or any write while a run is active
      err_q <= cfg.cfg_we && !(idle && addr_ok);
      if (wr_ok) begin
        for (int i = 0; i < N_TAP; i++) begin
          if (cfg.cfg_addr == ADDR_A0 + 6'(i)) a_reg[i] <= cfg.cfg_wdata[WIDTH-1:0];
          if (cfg.cfg_addr == ADDR_B0 + 6'(i)) b_reg[i] <= cfg.cfg_wdata[WIDTH-1:0];
        end
        for (int i = 0; i < N_CELL; i++) begin
          if (cfg.cfg_addr == ADDR_U0 + 6'(i)) u_reg[i] <= cfg.cfg_wdata[WIDTH-1:0];
        end
        if (cfg.cfg_addr == ADDR_I)     i_bias   <= cfg.cfg_wdata[WIDTH-1:0];
        // Limit is the low ITER_W bits of the data word, zero-extended
        if (cfg.cfg_addr == ADDR_MAXIT) max_iter <= ITER_W'(cfg.cfg_wdata);
      end
    end
  end

  assign cfg.cfg_err = err_q;

  always_comb begin
    a_tmpl = '0;
    b_tmpl = '0;
    u_out  = '0;
    for (int i = 0; i < N_TAP; i++) begin
      a_tmpl[i*WIDTH +: WIDTH] = a_reg[i];
      b_tmpl[i*WIDTH +: WIDTH] = b_reg[i];
    end
    for (int i = 0; i < N_CELL; i++) begin
      u_out[i*WIDTH +: WIDTH] = u_reg[i];
    end
  end

endmodule

// File: rtl/cnn_run_ctrl.sv
// ---------------------------------------------------------------------------
// cnn_run_ctrl
//   Run controller for the 4x4 CNN array. Holds the configuration, starts
//   the array, watches Y for convergence or the iteration limit, and
//   latches the final Y image.
//   clk, rst_n : clock, asynchronous active-low reset
//   cfg        : config write bus (slave), includes cfg_err
//   start      : run request (level, honoured only in IDLE)
//   abort      : cancel current run (INIT/RUN)
//   y_in       : array outputs Y1..Y16, Y1 in LSBs
//   a_tmpl, b_tmpl, u_out, i_bias : configuration to the array
//   arr_init   : 1-cycle initial-state load pulse
//   arr_en     : array state-update enable (RUN)
//   busy       : INIT or RUN
//   done       : 1-cycle completion pulse
//   converged  : result flag, valid with done, held until next start
//   iter_cnt   : arr_en cycles of the last/current run
//   y_result   : Y image captured in the done cycle
// ---------------------------------------------------------------------------
module cnn_run_ctrl
  import cnn_pkg::*;
#(
  parameter int ITER_W        = 16,
  parameter int STABLE_CYCLES = 4,
  parameter int ARR_LAT       = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cnn_run_ctrl_if.slave             cfg,
  input  logic                      start,
  input  logic                      abort,
  input  logic [N_CELL*WIDTH-1:0]   y_in,
  output logic [N_TAP*WIDTH-1:0]    a_tmpl,
  output logic [N_TAP*WIDTH-1:0]    b_tmpl,
  output logic [N_CELL*WIDTH-1:0]   u_out,
  output logic [WIDTH-1:0]          i_bias,
  output logic                      arr_init,
  output logic                      arr_en,
  output logic                      busy,
  output logic                      done,
  output logic                      converged,
  output logic [ITER_W-1:0]         iter_cnt,
  output logic [N_CELL*WIDTH-1:0]   y_result
);

  localparam int                 SC_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [SC_W-1:0]    SC_LAST = SC_W'(STABLE_CYCLES - 1);
  localparam logic [ITER_W-1:0]  LAT     = ITER_W'(ARR_LAT);

  run_state_t                state;
  run_state_t                state_nxt;
  logic                      idle;
  logic [ITER_W-1:0]         max_iter;
  logic [ITER_W-1:0]         iter_nxt;
  logic [SC_W-1:0]           stable_cnt;
  logic [N_CELL*WIDTH-1:0]   y_prev;
  logic                      y_same;
  logic                      cmp_en;
  logic                      conv_hit;
  logic                      lim_hit;

  assign idle = (state == ST_IDLE);

  cnn_cfg_regfile #(
    .ITER_W (ITER_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle     (idle),
    .cfg      (cfg),
    .a_tmpl   (a_tmpl),
    .b_tmpl   (b_tmpl),
    .u_out    (u_out),
    .i_bias   (i_bias),
    .max_iter (max_iter)
  );

  // iter_cnt equals the RUN cycle index k before its increment, so it
  // doubles as the latency mask counter.
  assign iter_nxt = iter_cnt + ITER_W'(1);
  assign y_same   = (y_in == y_prev);
  assign cmp_en   = (iter_cnt >= LAT);
  assign conv_hit = cmp_en && y_same && (stable_cnt == SC_LAST);
  assign lim_hit  = (iter_nxt == max_iter);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_INIT;
      ST_INIT: begin
        if (abort)                 state_nxt = ST_IDLE;
        else if (max_iter == '0)   state_nxt = ST_DONE;
        else                       state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort)                  state_nxt = ST_IDLE;
        else if (conv_hit || lim_hit) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    arr_init = 1'b0;
    arr_en   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      ST_INIT: begin arr_init = 1'b1; busy = 1'b1; end
      ST_RUN:  begin arr_en   = 1'b1; busy = 1'b1; end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Run counters and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt   <= '0;
      stable_cnt <= '0;
      converged  <= 1'b0;
      y_result   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            iter_cnt   <= '0;
            stable_cnt <= '0;
            converged  <= 1'b0;
          end
        end
        ST_RUN: begin
          iter_cnt <= iter_nxt;
          if (cmp_en) stable_cnt <= y_same ? stable_cnt + SC_W'(1) : '0;
          // Convergence outranks the limit exit; abort leaves the flag alone
          if (!abort && conv_hit) converged <= 1'b1;
        end
        ST_DONE: y_result <= y_in;
        default: ;
      endcase
    end
  end

  // Previous Y image, only meaningful once compares are unmasked
  always_ff @(posedge clk) begin
    if (state == ST_RUN) y_prev <= y_in;
  end

endmodule

// File: tb/tb_cnn_run_ctrl.sv
module tb_cnn_run_ctrl;
  import cnn_pkg::*;

  localparam int ITER_W        = 16;
  localparam int STABLE_CYCLES = 4;
  localparam int ARR_LAT       = 1;
  localparam int YW            = N_CELL*WIDTH;
  localparam int TW            = N_TAP*WIDTH;
  localparam int SEQ_N         = 300;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [YW-1:0]     y_in;
  logic [TW-1:0]     a_tmpl;
  logic [TW-1:0]     b_tmpl;
  logic [YW-1:0]     u_out;
  logic [WIDTH-1:0]  i_bias;
  logic              arr_init;
  logic              arr_en;
  logic              busy;
  logic              done;
  logic              converged;
  logic [ITER_W-1:0] iter_cnt;
  logic [YW-1:0]     y_result;

  cnn_run_ctrl_if cfg_if();

  cnn_run_ctrl #(
    .ITER_W        (ITER_W),
    .STABLE_CYCLES (STABLE_CYCLES),
    .ARR_LAT       (ARR_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg       (cfg_if),
    .start     (start),
    .abort     (abort),
    .y_in      (y_in),
    .a_tmpl    (a_tmpl),
    .b_tmpl    (b_tmpl),
    .u_out     (u_out),
    .i_bias    (i_bias),
    .arr_init  (arr_init),
    .arr_en    (arr_en),
    .busy      (busy),
    .done      (done),
    .converged (converged),
    .iter_cnt  (iter_cnt),
    .y_result  (y_result)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state
  logic [WIDTH-1:0] a_m [N_TAP];
  logic [WIDTH-1:0] b_m [N_TAP];
  logic [WIDTH-1:0] u_m [N_CELL];
  logic [WIDTH-1:0] i_m;
  int               maxit_m;
  logic [YW-1:0]    yseq [SEQ_N];
  logic [YW-1:0]    last_ydone;

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] data;
    bit          exp_err;
  } wr_vec_t;
  wr_vec_t tbl [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [YW-1:0] splat(input logic [WIDTH-1:0] v);
    logic [YW-1:0] r;
    for (int i = 0; i < N_CELL; i++) r[i*WIDTH +: WIDTH] = v;
    return r;
  endfunction

  function automatic logic [YW-1:0] rand_y();
    logic [YW-1:0] r;
    for (int i = 0; i < N_CELL; i++) r[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_TAP; i++) begin a_m[i] = '0; b_m[i] = '0; end
    for (int i = 0; i < N_CELL; i++) u_m[i] = '0;
    i_m     = '0;
    maxit_m = 256;
  endtask

  task automatic check_cfg(input string tag);
    logic [TW-1:0] ea, eb;
    logic [YW-1:0] eu;
    for (int i = 0; i < N_TAP; i++) begin
      ea[i*WIDTH +: WIDTH] = a_m[i];
      eb[i*WIDTH +: WIDTH] = b_m[i];
    end
    for (int i = 0; i < N_CELL; i++) eu[i*WIDTH +: WIDTH] = u_m[i];
    check({tag, " a_tmpl"}, a_tmpl, ea);
    check({tag, " b_tmpl"}, b_tmpl, eb);
    check({tag, " u_out"},  u_out,  eu);
    check({tag, " i_bias"}, i_bias, i_m);
  endtask

  // Idle-time config write; reference updated from the address map
  task automatic cfg_wr(input logic [5:0] addr, input logic [15:0] data, input bit exp_err);
    int a;
    a = int'(addr);
    cfg_if.cfg_we    = 1'b1;
    cfg_if.cfg_addr  = addr;
    cfg_if.cfg_wdata = data;
    tick();
    cfg_if.cfg_we = 1'b0;
    if (a < 9)       a_m[a]      = data[WIDTH-1:0];
    else if (a < 18) b_m[a-9]    = data[WIDTH-1:0];
    else if (a < 34) u_m[a-18]   = data[WIDTH-1:0];
    else if (a == 34) i_m        = data[WIDTH-1:0];
    else if (a == 35) maxit_m    = int'(data);
    check($sformatf("cfg_err addr %0d", a), cfg_if.cfg_err, exp_err);
  endtask

  // Expected outcome: converge at the first k whose last STABLE_CYCLES
  // unmasked comparisons all saw an unchanged image; else stop at limit.
  task automatic model_run(input int maxit, output int it, output bit cv);
    it = 0;
    cv = 1'b0;
    if (maxit == 0) return;
    for (int k = 0; k < SEQ_N; k++) begin
      if (k - STABLE_CYCLES + 1 >= ARR_LAT) begin
        bit all_eq;
        all_eq = 1'b1;
        for (int j = k - STABLE_CYCLES + 1; j <= k; j++)
          if (yseq[j] != yseq[j-1]) all_eq = 1'b0;
        if (all_eq) begin it = k + 1; cv = 1'b1; return; end
      end
      if (k + 1 == maxit) begin it = k + 1; return; end
    end
  endtask

  task automatic run(input string tag, input logic [YW-1:0] ydone);
    int            exp_it;
    bit            exp_cv;
    int            k;
    int            cyc;
    bit            seen_done;
    logic          got_cv;
    logic [ITER_W-1:0] got_it;
    model_run(maxit_m, exp_it, exp_cv);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " arr_init"}, arr_init, 1'b1);
    check({tag, " busy init"}, busy, 1'b1);
    k = 0; cyc = 0; seen_done = 1'b0; got_cv = 1'b0; got_it = '0;
    while (!seen_done && cyc < maxit_m + 20) begin
      if (arr_en) begin
        if (k < SEQ_N) y_in = yseq[k];
        k++;
      end else if (done) begin
        seen_done = 1'b1;
        got_cv    = converged;
        got_it    = iter_cnt;
        check({tag, " busy done"}, busy, 1'b0);
        y_in = ydone;
      end
      tick();
      cyc++;
    end
    check({tag, " done seen"}, seen_done, 1'b1);
    check({tag, " converged"}, got_cv, exp_cv);
    check({tag, " iter_cnt"}, got_it, exp_it);
    check({tag, " arr_en cycles"}, k, exp_it);
    check({tag, " y_result"}, y_result, ydone);
    check({tag, " done one cycle"}, done, 1'b0);
    last_ydone = ydone;
  endtask

  task automatic fill_alt();
    for (int k = 0; k < SEQ_N; k++) yseq[k] = (k % 2 == 1) ? splat(ONE) : splat(NEG_ONE);
  endtask

  task automatic fill_const(input logic [YW-1:0] v);
    for (int k = 0; k < SEQ_N; k++) yseq[k] = v;
  endtask

  initial begin
    rst_n            = 1'b0;
    start            = 1'b0;
    abort            = 1'b0;
    y_in             = '0;
    cfg_if.cfg_we    = 1'b0;
    cfg_if.cfg_addr  = '0;
    cfg_if.cfg_wdata = '0;
    model_reset();
    last_ydone = '0;

    // Power-on reset state
    repeat (2) tick();
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst arr_en", arr_en, 1'b0);
    check("rst iter_cnt", iter_cnt, 0);
    check("rst y_result", y_result, 0);
    rst_n = 1'b1;
    tick();
    check_cfg("rst cfg");

    // Table-driven config writes (edge-detect template + rejects)
    tbl.push_back('{6'd4,  16'h0010, 1'b0});
    for (int i = 0; i < 9; i++)
      if (i != 4) tbl.push_back('{6'(9 + i), 16'h01F0, 1'b0});
    tbl.push_back('{6'd13, 16'h0040, 1'b0});
    tbl.push_back('{6'd23, 16'h0010, 1'b0});
    tbl.push_back('{6'd24, 16'h0010, 1'b0});
    tbl.push_back('{6'd27, 16'h0010, 1'b0});
    tbl.push_back('{6'd28, 16'h0010, 1'b0});
    tbl.push_back('{6'd34, 16'h01B0, 1'b0});
    tbl.push_back('{6'd40, 16'h01FF, 1'b1});
    tbl.push_back('{6'd63, 16'h0123, 1'b1});
    foreach (tbl[n]) begin
      cfg_wr(tbl[n].addr, tbl[n].data, tbl[n].exp_err);
      check_cfg($sformatf("tbl%0d", n));
    end
    tick();
    check("cfg_err pulse ends", cfg_if.cfg_err, 1'b0);

    // Convergence with default limit
    fill_const(splat(ONE));
    run("conv", splat(ONE));

    // Iteration limit, then zero limit
    cfg_wr(6'd35, 16'd10, 1'b0);
    fill_alt();
    run("lim10", rand_y());
    cfg_wr(6'd35, 16'd0, 1'b0);
    run("lim0", rand_y());

    // Both exits in the same cycle
    cfg_wr(6'd35, 16'd5, 1'b0);
    fill_const(splat(NEG_ONE));
    run("both", rand_y());

    // Abort at RUN k=3 with a rejected write at k=1
    cfg_wr(6'd35, 16'd100, 1'b0);
    fill_alt();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      y_in = yseq[k];
      if (k == 1) begin
        cfg_if.cfg_we    = 1'b1;
        cfg_if.cfg_addr  = 6'd0;
        cfg_if.cfg_wdata = 16'h0055;
      end
      if (k == 3) abort = 1'b1;
      tick();
      cfg_if.cfg_we = 1'b0;
      if (k == 1) check("run wr cfg_err", cfg_if.cfg_err, 1'b1);
      if (k < 3)  check($sformatf("abort run k%0d", k + 1), arr_en, 1'b1);
    end
    abort = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort arr_en", arr_en, 1'b0);
    check("abort iter_cnt", iter_cnt, 4);
    check("abort y_result", y_result, last_ydone);
    check("abort converged", converged, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (done) seen = 1'b1;
        tick();
      end
      check("abort no done", seen, 1'b0);
    end
    check_cfg("after abort");

    // Randomized runs against the reference model
    for (int r = 0; r < 20; r++) begin
      int mi;
      mi = $urandom_range(1, 40);
      cfg_wr(6'd35, 16'(mi), 1'b0);
      yseq[0] = rand_y();
      for (int k = 1; k < SEQ_N; k++)
        yseq[k] = ($urandom_range(0, 9) < 7) ? yseq[k-1] : rand_y();
      run($sformatf("rnd%0d", r), rand_y());
    end

    // Asynchronous reset in the middle of a run
    fill_alt();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) begin
      y_in = yseq[0];
      tick();
    end
    #3 rst_n = 1'b0;
    #1;
    check("mid rst busy", busy, 1'b0);
    check("mid rst arr_en", arr_en, 1'b0);
    check("mid rst iter_cnt", iter_cnt, 0);
    check("mid rst y_result", y_result, 0);
    check("mid rst converged", converged, 1'b0);
    model_reset();
    check_cfg("mid rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    run("default256", rand_y());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
